// File: rtl/snake_input_conditioner.sv
// snake_input_conditioner
//   Synchronises and debounces the four BASYS3 direction buttons and the
//   GAME_IN switch before they reach snake_wrapper. It produces clean levels
//   and single-cycle press pulses. The press pulses are arbitrated so that at
//   most one direction fires per cycle, with priority U > D > L > R.
//
// Ports
//   CLK, RESET                 clock, async active-high reset
//   BTN{U,D,L,R}_RAW           raw bouncing buttons
//   GAME_IN_RAW                raw timed-mode switch
//   BTN{U,D,L,R}, GAME_IN      debounced levels
//   PRESS[3:0]                 arbitrated press pulse {U,D,L,R}
//   ANY_PRESS                  OR of the un-arbitrated press pulses

// One conditioning lane: a 2-flop synchroniser followed by a debounce counter.
// level   = the accepted stable value.
// rise    = combinational; high on the edge where stable will go 0->1.
module snake_ic_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2, stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // A bounce back to the stable value restarts the count from zero.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = stable;
    assign rise  = (cnt == CNT_MAX) && sync2 && !stable;
endmodule

module snake_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTNU_RAW,
    input  logic       BTND_RAW,
    input  logic       BTNL_RAW,
    input  logic       BTNR_RAW,
    input  logic       GAME_IN_RAW,
    output logic       BTNU,
    output logic       BTND,
    output logic       BTNL,
    output logic       BTNR,
    output logic       GAME_IN,
    output logic [3:0] PRESS,
    output logic       ANY_PRESS
);
    localparam int NUM_CH = 5;

    // Bits [3:0] follow the PRESS order {U,D,L,R}. Bit 4 is GAME_IN, which
    // never produces a pulse.
    logic [NUM_CH-1:0] raw_vec, lvl_vec, rise_vec;
    logic [3:0]        press_arb;

    assign raw_vec = {GAME_IN_RAW, BTNU_RAW, BTND_RAW, BTNL_RAW, BTNR_RAW};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        snake_ic_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk  (CLK),
            .rst  (RESET),
            .raw  (raw_vec[i]),
            .level(lvl_vec[i]),
            .rise (rise_vec[i])
        );
    end

    // Fixed priority U > D > L > R. A suppressed press is dropped.
    always_comb begin
        press_arb = 4'b0000;
        if      (rise_vec[3]) press_arb = 4'b1000;
        else if (rise_vec[2]) press_arb = 4'b0100;
        else if (rise_vec[1]) press_arb = 4'b0010;
        else if (rise_vec[0]) press_arb = 4'b0001;
    end

    // Registering the pulses from the qualifying edge makes them coincide
    // with the rising level.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PRESS     <= 4'b0000;
            ANY_PRESS <= 1'b0;
        end else begin
            PRESS     <= press_arb;
            ANY_PRESS <= |rise_vec[3:0];
        end
    end

    assign BTNU    = lvl_vec[3];
    assign BTND    = lvl_vec[2];
    assign BTNL    = lvl_vec[1];
    assign BTNR    = lvl_vec[0];
    assign GAME_IN = lvl_vec[4];
endmodule

// File: doc/snake_input_conditioner.md
# snake_input_conditioner

Front-end stage that conditions the raw BASYS3 push-buttons (BTNU/BTND/BTNL/BTNR) and the GAME_IN switch before they reach snake_wrapper. Each input is double-flop synchronised and debounced; the block outputs clean levels plus single-cycle press pulses. Simultaneous presses are arbitrated so that at most one direction pulse fires per cycle. The outputs drive the wrapper's BTNx/GAME_IN ports. The Master and Navigation state machines then see glitch-free inputs.

## Interface
- DEBOUNCE_CYCLES, 1000000 — consecutive cycles a synchronised input must differ from its stable value before the change is accepted (10 ms at 100 MHz); legal minimum 2.
- CNT_W, 20 — counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.
- CLK  input  1  system clock; all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- BTNU_RAW, BTND_RAW, BTNL_RAW, BTNR_RAW  input  1 each  raw, asynchronous, bouncing buttons.
- GAME_IN_RAW  input  1  raw timed-mode switch.
- BTNU, BTND, BTNL, BTNR  output  1 each  debounced button levels.
- GAME_IN  output  1  debounced switch level.
- PRESS  output  4  one-cycle press pulses {U,D,L,R} = bits [3:0], after arbitration.
- ANY_PRESS  output  1  OR of the un-arbitrated press pulses.

## Operation
- Five identical channels: 4 buttons plus GAME_IN. Each channel holds sync1, sync2, stable, and a cnt[CNT_W-1:0].
- Synchroniser: sync1 <= raw; sync2 <= sync1.
- Debounce, evaluated per edge:
  - if sync2 == stable: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - else: cnt <= cnt+1.
- A bounce back to the stable value before the count completes clears cnt to 0; counting restarts from zero on the next difference.
- Level outputs equal the stable registers directly.
- Raw press vector: rp[i] asserts on the edge where button i's stable goes 0->1, i.e. cnt == DEBOUNCE_CYCLES-1 && sync2 && !stable.
- rp is registered, so it is coincident with the level rising. Releases (1->0) produce no pulse. GAME_IN has no pulse.
- Arbitration: priority U > D > L > R. PRESS = the highest-priority set bit of rp, all other bits 0; PRESS is one-hot or zero.
- ANY_PRESS = |rp; it is not arbitrated.
- cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

## Timing
- Reset (async assert, synchronous-domain release): all sync, stable, cnt, PRESS and ANY_PRESS registers are 0. Outputs are 0 while RESET is high.
- Latency, raw rise to level: raw changes before edge 0 and stays.
  - sync2 = 1 after edge 1.
  - Counting runs on edges 2..DEBOUNCE_CYCLES+1.
  - stable and PRESS bit = 1 after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 cycles after the change.
- PRESS and ANY_PRESS are high for exactly one cycle; the level stays high while the button is held.
- Release latency is identical: DEBOUNCE_CYCLES+2 cycles.
- Simultaneous qualified presses in the same cycle: only the highest-priority bit appears on PRESS, and ANY_PRESS = 1. The suppressed press is lost; no re-queue.
- Presses qualifying in different cycles each produce their own pulse.
- Reset mid-count: cnt is cleared. If an input is held high through reset release, its rise and pulse are re-reported DEBOUNCE_CYCLES+2 cycles after release. GAME_IN likewise rises that long after release.
- A held button never produces a second pulse without an intervening debounced release.

## Test plan
1. Reset, DEBOUNCE_CYCLES=4. Hold all raw inputs 0 for 20 cycles -> all outputs 0, PRESS=4'b0000 throughout.
2. BTNU_RAW 0->1 before edge 0, held -> BTNU=1 and PRESS=4'b1000 after edge 5; PRESS returns to 0 after edge 6; BTNU stays 1.
3. BTNL_RAW pulses high for 3 cycles (sync2 high for 3 edges < 4), then low -> BTNL stays 0, no PRESS. Then held high -> pulse after the 4-cycle count from restart.
4. BTND_RAW and BTNR_RAW rise on the same cycle -> PRESS=4'b0100 for one cycle, ANY_PRESS=1 that cycle, BTND=BTNR=1 afterwards.
5. BTNR held high; assert RESET mid-count (cnt=2), release one cycle later -> all outputs 0 during reset; BTNR=1 and PRESS=4'b0001 six cycles after release.
6. GAME_IN_RAW 0->1, then 1->0 after 10 cycles -> GAME_IN rises after edge 5 and falls 6 cycles after the raw fall; PRESS and ANY_PRESS stay 0 throughout.
